eth_reg_readback: RTL
=====================

Name: eth_reg_readback

Overview:
- Read-side responder for the MAC register file.
- Accepts host read requests, selects one of NUM_REGS register outputs from a flattened bus, inserts programmable wait states, and returns registered data with a one-cycle acknowledge.
- Sits between the host bus interface and the bank of write-side register instances; complements their write path.

Parameters:
- WIDTH, 32: register data width in bits.
- NUM_REGS, 16: number of readable registers (1..2^ADDR_W).
- ADDR_W, 4: read address width.
- WAIT_STATES, 1: wait cycles before acknowledge, 0..7.
- CLR_ADDR, 1: address of the clear-on-read register; used only with the optional feature.

Ports:
- Clk  input  1  clock; all logic on rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- SyncReset  input  1  synchronous reset; same effect as Resetn, applied on the clock edge.
- RdReq  input  1  read request; host holds it high until RdAck.
- RdAddr  input  ADDR_W  register index; must stay stable while RdReq is high.
- RegData  input  NUM_REGS*WIDTH  flattened register outputs; register i occupies bits [i*WIDTH +: WIDTH].
- RdData  output  WIDTH  read data; valid in the RdAck cycle, held afterwards.
- RdAck  output  1  one-cycle acknowledge pulse.
- RdErr  output  1  asserted with RdAck when RdAddr >= NUM_REGS.
- Busy  output  1  high whenever the FSM is not in IDLE.
- ClrPulse  output  1  one-cycle clear strobe to the clear-on-read register.

Behaviour:
- Reset values (Resetn low, or SyncReset high at a clock edge):
  - RdData = 0, RdAck = 0, RdErr = 0, Busy = 0, ClrPulse = 0.
  - FSM in IDLE; wait counter = 0.
- FSM states: IDLE, WAIT, ACK.
- IDLE:
  - RdReq = 1: latch RdAddr into AddrQ.
  - If WAIT_STATES = 0, go to ACK; otherwise load the counter with WAIT_STATES-1 and go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - When the counter reaches 0, go to ACK.
- ACK:
  - RdAck = 1 for exactly this cycle; RdErr = 1 in the same cycle if AddrQ >= NUM_REGS.
  - Unconditionally return to IDLE.
- Data capture:
  - RdData is loaded on the clock edge entering ACK, from RegData[AddrQ], so data reflects register contents one cycle before RdAck.
  - Out-of-range AddrQ loads 0.
  - RdData holds its value until the next ACK.
- Latency: RdAck asserts WAIT_STATES+1 cycles after the edge that samples RdReq in IDLE.
  - WAIT_STATES = 0: ack in the cycle after request.
  - WAIT_STATES = 7: ack 8 cycles later.
- Back-to-back reads: ACK always returns to IDLE, so a request held high is re-sampled the cycle after RdAck. Minimum request-to-request spacing is WAIT_STATES+2 cycles; the host must drop RdReq in the ACK cycle to avoid a duplicate read.
- Abort: RdReq low while in WAIT returns the FSM to IDLE next cycle. No RdAck, no RdData update, no ClrPulse.
- Reset mid-transaction: immediate return to IDLE; any pending ack is dropped.
- Busy is derived combinationally from state (state != IDLE).
- AddrQ is only updated in IDLE; RdAddr changes during WAIT are ignored.

Optional Feature:
- Macro: ETH_REG_CLEAR_ON_READ_EN.
- Defined:
  - ClrPulse = 1 in the ACK cycle when AddrQ == CLR_ADDR and RdErr = 0.
  - The interrupt-source register uses ClrPulse as a SyncReset, clearing it the cycle after the read.
  - Data returned is the pre-clear value.
- Not defined: ClrPulse is tied to 0 and no compare logic is built.

Test Plan:
- Basic read, WAIT_STATES=1: register 3 = 0xDEADBEEF; RdReq with RdAddr=3 at cycle 0 -> RdAck and RdData=0xDEADBEEF at cycle 2, RdErr=0, Busy high in cycles 1-2.
- Zero wait, WAIT_STATES=0: read addr 0 (0x00000001) -> RdAck the cycle after the request. Then read addr 15 (0xA5A5A5A5) with RdReq dropped in the ACK cycle -> exactly one ack per read, correct data each.
- Out of range, NUM_REGS=12: read addr 13 -> RdAck with RdErr=1 and RdData=0. Following read of addr 2 -> RdErr=0.
- Abort, WAIT_STATES=5: RdReq high 2 cycles then low -> no RdAck, RdData unchanged, Busy low by the cycle after deassertion.
- Reset mid-read: Resetn low during WAIT -> all outputs 0 immediately. SyncReset during WAIT (separate run) -> all outputs 0 at the next edge; next read completes normally.
- Clear-on-read, macro defined, CLR_ADDR=1: register 1 = 0x0000_0024 -> RdData=0x24 with ClrPulse=1 in the ack cycle; re-read -> 0. Read of addr 2 -> ClrPulse=0. Macro undefined -> ClrPulse never asserts.

Source files
------------

// File: rtl/eth_reg_readback.sv
// Read-side responder for the MAC register file: selects one register, waits WAIT_STATES cycles, returns data with a one-cycle ack.
// Optional clear-on-read strobe is built only when ETH_REG_CLEAR_ON_READ_EN is defined.
module eth_reg_readback #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned CLR_ADDR    = 1
) (
    input  logic                      Clk,
    input  logic                      Resetn,
    input  logic                      SyncReset,
    input  logic                      RdReq,
    input  logic [ADDR_W-1:0]         RdAddr,
    input  logic [NUM_REGS*WIDTH-1:0] RegData,
    output logic [WIDTH-1:0]          RdData,
    output logic                      RdAck,
    output logic                      RdErr,
    output logic                      Busy,
    output logic                      ClrPulse
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

    // Elaboration-time parameter sanity checks
    if (WAIT_STATES > 7) begin : gBadWait
        $error("WAIT_STATES must be 0..7");
    end
    if (NUM_REGS < 1 || NUM_REGS > (1 << ADDR_W)) begin : gBadRegs
        $error("NUM_REGS must be 1..2^ADDR_W");
    end
    if (CLR_ADDR >= (1 << ADDR_W)) begin : gBadClr
        $error("CLR_ADDR must be addressable by RdAddr");
    end

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2
    } state_t;

    state_t            state;
    state_t            nextState;
    logic [CNT_W-1:0]  waitCnt;
    logic [ADDR_W-1:0] addrQ;
    logic [ADDR_W-1:0] selAddr_c;
    logic [WIDTH-1:0]  selData_c;
    logic              addrErr_c;
    logic              enterAck_c;

    // State register
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state <= StIdle;
        end else if (SyncReset) begin
            state <= StIdle;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; a dropped request in WAIT aborts the read
    always_comb begin
        nextState = state;
        unique case (state)
            StIdle: begin
                if (RdReq) begin
                    nextState = (WAIT_STATES == 0) ? StAck : StWait;
                end
            end
            StWait: begin
                if (!RdReq) begin
                    nextState = StIdle;
                end else if (waitCnt == '0) begin
                    nextState = StAck;
                end
            end
            StAck:   nextState = StIdle;
            default: nextState = StIdle;
        endcase
    end

    // With zero wait states AddrQ is not yet loaded when data is captured, so use RdAddr directly
    assign selAddr_c  = (state == StIdle) ? RdAddr : addrQ;
    assign enterAck_c = (nextState == StAck) && (state != StAck);
    assign addrErr_c  = 32'(addrQ) >= NUM_REGS;

    // Register select; out-of-range addresses fall through to zero
    always_comb begin
        selData_c = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (selAddr_c == ADDR_W'(i)) begin
                selData_c = RegData[i*WIDTH +: WIDTH];
            end
        end
    end

    // Address latch, wait counter and read-data register
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            waitCnt <= '0;
            addrQ   <= '0;
            RdData  <= '0;
        end else if (SyncReset) begin
            waitCnt <= '0;
            addrQ   <= '0;
            RdData  <= '0;
        end else begin
            if (state == StIdle && RdReq) begin
                addrQ   <= RdAddr;
                waitCnt <= CNT_LOAD;
            end else if (state == StWait && waitCnt != '0) begin
                waitCnt <= waitCnt - CNT_W'(1);
            end
            if (enterAck_c) begin
                RdData <= selData_c;
            end
        end
    end

    // Output decode from state
    always_comb begin
        RdAck    = 1'b0;
        RdErr    = 1'b0;
        ClrPulse = 1'b0;
        Busy     = (state != StIdle);
        if (state == StAck) begin
            RdAck = 1'b1;
            RdErr = addrErr_c;
`ifdef ETH_REG_CLEAR_ON_READ_EN
            ClrPulse = !addrErr_c && (32'(addrQ) == CLR_ADDR);
`else
            ClrPulse = 1'b0;
`endif
        end
    end

endmodule
